// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage driving a one-cycle registered ALU, with hazard tracking and branch sequencing.
// Build option: define ALU_ISSUE_FWD_EN to forward the RES-slot result from alu_res instead of stalling.
package alu_issue_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_LT, OP_LTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_EQ, OP_NEQ, OP_GE, OP_GEU
  } op_t;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        out_valid,
  output op_t         out_op,
  output logic [31:0] out_src1,
  output logic [31:0] out_src2,
  input  logic [31:0] alu_res,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        illegal
);

  typedef enum logic [1:0] {S_RUN, S_BR_EX, S_BR_RES, S_HALT} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t      state_q;
  logic        out_valid_q, illegal_q;
  op_t         out_op_q;
  logic [31:0] out_src1_q, out_src2_q, br_tgt_q;
  logic        ex_wb_q, res_wb_q;
  logic [4:0]  ex_rd_q, res_rd_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_u, imm_b;
  logic        use_rs1, use_rs2;
  logic        ex_hit1, ex_hit2, res_hit1, res_hit2, stall, accept;
  logic [31:0] rs1_val, rs2_val;
  op_t         op_d;
  logic [31:0] src1_d, src2_d;
  logic        wb_d, br_d, ill_d;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'h000};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // Only sources the instruction actually reads may raise a hazard.
  assign use_rs1 = (opcode == OPC_OP) || (opcode == OPC_IMM) || (opcode == OPC_BRANCH);
  assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_BRANCH);

  function automatic op_t arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_LT;
      3'b011:  return OP_LTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  always_comb begin
    ex_hit1  = ex_wb_q  && use_rs1 && (rs1 == ex_rd_q);
    ex_hit2  = ex_wb_q  && use_rs2 && (rs2 == ex_rd_q);
    res_hit1 = res_wb_q && use_rs1 && (rs1 == res_rd_q);
    res_hit2 = res_wb_q && use_rs2 && (rs2 == res_rd_q);
`ifdef ALU_ISSUE_FWD_EN
    stall   = ex_hit1 || ex_hit2;
    rs1_val = res_hit1 ? alu_res : rf_rs1_data;
    rs2_val = res_hit2 ? alu_res : rf_rs2_data;
`else
    stall   = ex_hit1 || ex_hit2 || res_hit1 || res_hit2;
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
`endif
  end

`ifndef ALU_ISSUE_FWD_EN
  logic unused_alu_res;
  assign unused_alu_res = ^alu_res[31:1];
`endif

  always_comb begin
    op_d   = OP_ADD;
    src1_d = rs1_val;
    src2_d = rs2_val;
    wb_d   = 1'b0;
    br_d   = 1'b0;
    ill_d  = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_d = arith_op(funct3, in_instr[30]);
        wb_d = 1'b1;
      end
      OPC_IMM: begin
        op_d   = arith_op(funct3, in_instr[30] && (funct3 == 3'b101));
        src2_d = imm_i;
        wb_d   = 1'b1;
      end
      OPC_LUI: begin
        src1_d = '0;
        src2_d = imm_u;
        wb_d   = 1'b1;
      end
      OPC_AUIPC: begin
        src1_d = in_pc;
        src2_d = imm_u;
        wb_d   = 1'b1;
      end
      OPC_BRANCH: begin
        br_d = 1'b1;
        case (funct3)
          3'b000:  op_d = OP_EQ;
          3'b001:  op_d = OP_NEQ;
          3'b100:  op_d = OP_LT;
          3'b101:  op_d = OP_GE;
          3'b110:  op_d = OP_LTU;
          3'b111:  op_d = OP_GEU;
          default: ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
    if (rd == 5'd0) wb_d = 1'b0;
  end

  assign in_ready = (state_q == S_RUN) && !stall;
  assign accept   = in_valid && in_ready;

  // Every non-accept cycle falls through to the bubble defaults below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
      out_op_q    <= OP_ADD;
      out_src1_q  <= '0;
      out_src2_q  <= '0;
      br_tgt_q    <= '0;
      ex_wb_q     <= 1'b0;
      ex_rd_q     <= '0;
      res_wb_q    <= 1'b0;
      res_rd_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_op_q    <= OP_ADD;
      out_src1_q  <= '0;
      out_src2_q  <= '0;
      ex_wb_q     <= 1'b0;
      ex_rd_q     <= '0;
      illegal_q   <= 1'b0;
      res_wb_q    <= ex_wb_q;
      res_rd_q    <= ex_rd_q;
      case (state_q)
        S_RUN: begin
          if (accept) begin
            if (ill_d) begin
              illegal_q <= 1'b1;
              if (ILLEGAL_HALT) state_q <= S_HALT;
            end else begin
              out_valid_q <= 1'b1;
              out_op_q    <= op_d;
              out_src1_q  <= src1_d;
              out_src2_q  <= src2_d;
              ex_wb_q     <= wb_d;
              ex_rd_q     <= wb_d ? rd : 5'd0;
              if (br_d) begin
                state_q  <= S_BR_EX;
                br_tgt_q <= in_pc + imm_b;
              end
            end
          end
        end
        S_BR_EX:  state_q <= S_BR_RES;
        S_BR_RES: state_q <= S_RUN;
        default:  state_q <= S_HALT;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_op         = out_op_q;
  assign out_src1       = out_src1_q;
  assign out_src2       = out_src2_q;
  assign wb_en          = res_wb_q;
  assign wb_rd          = res_rd_q;
  assign illegal        = illegal_q;
  assign redirect_valid = (state_q == S_BR_RES) && alu_res[0];
  assign redirect_pc    = br_tgt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: ISA-level model, registered ALU model and writeback regfile.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
  localparam int GAP_B2B = 2;
  localparam int GAP_D2  = 1;
`else
  localparam int GAP_B2B = 3;
  localparam int GAP_D2  = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, wb_en, redirect_valid, illegal;
  logic [31:0] in_instr, in_pc, rf_rs1_data, rf_rs2_data, out_src1, out_src2, alu_res, redirect_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, wb_rd;
  op_t         out_op;

  logic        h_rst_n, h_valid, h_ready, h_out_valid, h_wb_en, h_redir_v, h_illegal;
  logic [31:0] h_instr, h_pc, h_zero, h_src1, h_src2, h_redir_pc;
  logic [4:0]  h_rs1, h_rs2, h_wb_rd;
  op_t         h_op;

  alu_issue_stage #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .out_valid(out_valid),
    .out_op(out_op), .out_src1(out_src1), .out_src2(out_src2), .alu_res(alu_res),
    .wb_en(wb_en), .wb_rd(wb_rd), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .illegal(illegal)
  );

  alu_issue_stage #(.ILLEGAL_HALT(1'b1)) u_halt (
    .clk(clk), .rst_n(h_rst_n), .in_valid(h_valid), .in_ready(h_ready),
    .in_instr(h_instr), .in_pc(h_pc), .rf_rs1_addr(h_rs1), .rf_rs2_addr(h_rs2),
    .rf_rs1_data(h_zero), .rf_rs2_data(h_zero), .out_valid(h_out_valid),
    .out_op(h_op), .out_src1(h_src1), .out_src2(h_src2), .alu_res(h_zero),
    .wb_en(h_wb_en), .wb_rd(h_wb_rd), .redirect_valid(h_redir_v),
    .redirect_pc(h_redir_pc), .illegal(h_illegal)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_ill_exp = 0;
  int n_ill_seen = 0;
  int cyc = 0;
  logic tb_init;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_f(input op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_LT:   return {31'b0, $signed(a) < $signed(b)};
      OP_LTU:  return {31'b0, a < b};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_EQ:   return {31'b0, a == b};
      OP_NEQ:  return {31'b0, a != b};
      OP_GE:   return {31'b0, $signed(a) >= $signed(b)};
      OP_GEU:  return {31'b0, a >= b};
      default: return 32'h0;
    endcase
  endfunction

  // Environment: registered ALU and a regfile written by the DUT's writeback.
  logic [31:0] rf [32];
  always @(posedge clk) alu_res <= alu_f(out_op, out_src1, out_src2);
  always @(posedge clk)
    if (tb_init) for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    else if (wb_en === 1'b1 && wb_rd != 5'd0) rf[wb_rd] <= alu_res;
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  typedef struct { op_t op; logic [31:0] s1; logic [31:0] s2; logic [31:0] res;
                   logic wb; logic [4:0] rd; logic ill; } exp_t;
  typedef struct { op_t op; logic [31:0] s1; logic [31:0] s2; } iss_t;
  typedef struct { logic [4:0] rd; logic [31:0] v; } wbx_t;
  iss_t iss_q[$];
  wbx_t wb_q[$];
  logic [31:0] arch [32];

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    op_t rtab [8];
    logic [31:0] a, b, ii, uu;
    logic [2:0] f3;
    rtab = '{OP_ADD, OP_SLL, OP_LT, OP_LTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    a = arch[ins[19:15]]; b = arch[ins[24:20]]; f3 = ins[14:12];
    ii = {{20{ins[31]}}, ins[31:20]};
    uu = {ins[31:12], 12'h000};
    e.op = OP_ADD; e.s1 = 0; e.s2 = 0; e.wb = 0; e.ill = 0; e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.op = rtab[f3];
        if (ins[30] && f3 == 3'd0) e.op = OP_SUB;
        if (ins[30] && f3 == 3'd5) e.op = OP_SRA;
        e.s1 = a; e.s2 = b; e.wb = 1;
      end
      7'h13: begin
        e.op = rtab[f3];
        if (ins[30] && f3 == 3'd5) e.op = OP_SRA;
        e.s1 = a; e.s2 = ii; e.wb = 1;
      end
      7'h37: begin e.s2 = uu; e.wb = 1; end
      7'h17: begin e.s1 = pc; e.s2 = uu; e.wb = 1; end
      7'h63: begin
        e.s1 = a; e.s2 = b;
        case (f3)
          3'd0: e.op = OP_EQ;  3'd1: e.op = OP_NEQ;
          3'd4: e.op = OP_LT;  3'd5: e.op = OP_GE;
          3'd6: e.op = OP_LTU; 3'd7: e.op = OP_GEU;
          default: e.ill = 1;
        endcase
      end
      default: e.ill = 1;
    endcase
    if (e.rd == 5'd0) e.wb = 0;
    e.res = alu_f(e.op, e.s1, e.s2);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every issued instruction and every writeback.
  always @(negedge clk) begin : mon
    iss_t ei;
    wbx_t ew;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (iss_q.size() == 0) chk("spurious_issue", 32'd1, 32'd0);
        else begin
          ei = iss_q.pop_front();
          chk("out_op", out_op, ei.op);
          chk("out_src1", out_src1, ei.s1);
          chk("out_src2", out_src2, ei.s2);
        end
      end
      if (wb_en === 1'b1) begin
        if (wb_q.size() == 0) chk("spurious_wb", 32'd1, 32'd0);
        else begin
          ew = wb_q.pop_front();
          chk("wb_rd", wb_rd, ew.rd);
          chk("wb_data", alu_res, ew.v);
        end
      end
      if (illegal === 1'b1) n_ill_seen++;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output int acc);
    exp_t e;
    bit done;
    done = 0; acc = -1;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e = model(ins, pc);
        if (e.ill) n_ill_exp++;
        else begin
          iss_q.push_back('{e.op, e.s1, e.s2});
          if (e.wb) begin
            wb_q.push_back('{e.rd, e.res});
            arch[e.rd] = e.res;
          end
        end
        @(posedge clk); #1;
        acc = cyc; done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic br_test(input logic [31:0] ins, input logic [31:0] pc,
                         input logic exp_tk, input logic [31:0] exp_pc);
    int c;
    issue(ins, pc, c);
    @(negedge clk);
    chk("br_ex_ready", in_ready, 0);
    chk("br_ex_redir", redirect_valid, 0);
    @(negedge clk);
    chk("br_res_ready", in_ready, 0);
    chk("br_res_redir", redirect_valid, exp_tk);
    if (exp_tk) chk("br_res_pc", redirect_pc, exp_pc);
    @(negedge clk);
    chk("br_done_ready", in_ready, 1);
    chk("br_done_redir", redirect_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3;
    logic [31:0] prog[$];
    for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    tb_init = 1'b1; rst_n = 1'b0; h_rst_n = 1'b0;
    in_valid = 1'b1; in_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1); in_pc = 32'h0;
    h_valid = 1'b0; h_instr = 32'h13; h_pc = 32'h0; h_zero = 32'h0;

    // Reset held two cycles with a valid instruction present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_out_op", out_op, OP_ADD);
    chk("rst_src1", out_src1, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_redir", redirect_valid, 0);
    rst_n = 1'b1; h_rst_n = 1'b1; in_valid = 1'b0; tb_init = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back dependency.
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 32'h10, c1);
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h14, c2);
    chk("b2b_gap", c2 - c1, GAP_B2B);
    drain(4);

    // Distance-2 dependency with a stale regfile entry.
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd3), 32'h20, c1);
    issue(32'h00000013, 32'h24, c2);
    chk("d2_rf_stale", rf[3], 0);
    issue(enc_r(7'h20, 5'd0, 5'd3, 3'd0, 5'd4), 32'h28, c3);
    chk("d2_nop_gap", c2 - c1, 1);
    chk("d2_gap", c3 - c2, GAP_D2);
    drain(4);

    // Decode coverage across OP and OP-IMM.
    prog.push_back(enc_i(12'hFFD, 5'd0, 3'd0, 5'd7));
    prog.push_back(enc_i(12'h7F0, 5'd0, 3'd0, 5'd8));
    prog.push_back(enc_i(12'h004, 5'd8, 3'd1, 5'd9));
    prog.push_back(enc_i(12'h401, 5'd7, 3'd5, 5'd10));
    prog.push_back(enc_i(12'h01C, 5'd7, 3'd5, 5'd11));
    prog.push_back(enc_i(12'hFFF, 5'd0, 3'd3, 5'd12));
    prog.push_back(enc_i(12'h000, 5'd7, 3'd2, 5'd13));
    prog.push_back(enc_i(12'hFFF, 5'd7, 3'd4, 5'd14));
    prog.push_back(enc_i(12'h00F, 5'd8, 3'd6, 5'd15));
    prog.push_back(enc_i(12'h0F0, 5'd7, 3'd7, 5'd16));
    prog.push_back(enc_i(12'h400, 5'd0, 3'd0, 5'd27));
    prog.push_back(enc_r(7'h20, 5'd7, 5'd8, 3'd0, 5'd17));
    prog.push_back(enc_r(7'h00, 5'd11, 5'd8, 3'd1, 5'd18));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd2, 5'd19));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd3, 5'd20));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd4, 5'd21));
    prog.push_back(enc_r(7'h00, 5'd11, 5'd7, 3'd5, 5'd22));
    prog.push_back(enc_r(7'h20, 5'd11, 5'd7, 3'd5, 5'd23));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd6, 5'd24));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd7, 5'd25));
    foreach (prog[i]) issue(prog[i], 32'h400 + 32'(i) * 4, c1);
    drain(4);

    // LUI / AUIPC, including pc + imm wrap.
    issue(enc_u(20'hABCDE, 5'd5, 7'h37), 32'h500, c1);
    issue(enc_u(20'h00001, 5'd6, 7'h17), 32'hFFFFF000, c1);
    drain(4);

    // Branches.
    br_test(enc_b(13'd16, 5'd0, 5'd0, 3'd0), 32'h100, 1'b1, 32'h110);
    br_test(enc_b(13'd16, 5'd0, 5'd0, 3'd1), 32'h100, 1'b0, 32'h0);
    br_test(enc_b(13'h1FF8, 5'd8, 5'd7, 3'd4), 32'h200, 1'b1, 32'h1F8);
    br_test(enc_b(13'd32, 5'd8, 5'd7, 3'd6), 32'h200, 1'b0, 32'h0);
    br_test(enc_b(13'd32, 5'd8, 5'd7, 3'd7), 32'h200, 1'b1, 32'h220);
    br_test(enc_b(13'd16, 5'd0, 5'd0, 3'd0), 32'hFFFFFFF8, 1'b1, 32'h8);

    // Reset while a taken branch is in flight.
    issue(enc_b(13'd16, 5'd0, 5'd0, 3'd0), 32'h300, c1);
    @(negedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_br_redir", redirect_valid, 0);
    chk("rst_br_ready", in_ready, 1);
    @(posedge clk); #1;

    // Illegal instructions are dropped as bubbles.
    issue(32'h00000003, 32'h600, c1);
    @(negedge clk);
    chk("ill_pulse", illegal, 1);
    chk("ill_bubble", out_valid, 0);
    @(negedge clk);
    chk("ill_pulse_end", illegal, 0);
    chk("ill_ready", in_ready, 1);
    @(posedge clk); #1;
    issue(enc_b(13'd16, 5'd0, 5'd0, 3'd2), 32'h604, c1);
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd26), 32'h608, c1);
    drain(4);

    // Halting variant.
    h_valid = 1'b1; h_instr = 32'h00000003;
    @(negedge clk);
    chk("halt_pre_ready", h_ready, 1);
    @(posedge clk); #1;
    h_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
    @(negedge clk);
    chk("halt_pulse", h_illegal, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_ready", h_ready, 0);
      chk("halt_bubble", h_out_valid, 0);
      chk("halt_pulse_once", h_illegal, 0);
    end
    h_valid = 1'b0;
    h_rst_n = 1'b0;
    @(posedge clk); #1 h_rst_n = 1'b1;
    @(negedge clk);
    chk("halt_rst_ready", h_ready, 1);
    @(posedge clk); #1;

    chk("iss_q_empty", iss_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("illegal_count", n_ill_seen, n_ill_exp);
    chk("rf_x2", rf[2], 32'd10);
    chk("rf_x6", rf[6], 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
